// File: rtl/router_rr_switch_if.sv
// Channel bundle for router_rr_switch: valid/ready flit inputs, registered flit outputs
// and the drop counter.
interface router_rr_switch_if #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned DEST_W  = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ready;
    logic [NUM_IN-1:0]         in_last;
    logic [NUM_IN*DEST_W-1:0]  in_dest;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_ready;
    logic [NUM_OUT-1:0]        out_last;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT*SRC_W-1:0]  out_src;
    logic [CNT_W-1:0]          drop_cnt;

    modport master (
        output in_valid, in_last, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_src, drop_cnt
    );

    modport slave (
        input  in_valid, in_last, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_src, drop_cnt
    );
endinterface

// File: rtl/router_rr_switch.sv
// Packet switch: NUM_IN valid/ready inputs to NUM_OUT registered outputs, per-output
// round-robin arbitration with a per-packet lock; bad-destination packets are dropped.
module router_rr_switch #(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned NUM_OUT = 3,
    parameter int unsigned DEST_W  = 2,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    router_rr_switch_if.slave bus
);
    localparam int unsigned SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned SUM_W = CNT_W + 5;

    typedef enum logic [1:0] {InHead, InFwd, InDrop} in_state_e;
    typedef enum logic {OutIdle, OutLocked} out_state_e;

    in_state_e                 in_st_q   [NUM_IN];
    out_state_e                out_st_q  [NUM_OUT];
    logic [SRC_W-1:0]          owner_q   [NUM_OUT];
    logic [SRC_W-1:0]          ptr_q     [NUM_OUT];
    logic [NUM_OUT-1:0]        out_valid_q;
    logic [NUM_OUT-1:0]        out_last_q;
    logic [NUM_OUT*DATA_W-1:0] out_data_q;
    logic [NUM_OUT*SRC_W-1:0]  out_src_q;
    logic [CNT_W-1:0]          drop_cnt_q;

    logic [DEST_W-1:0]  dest [NUM_IN];
    logic [DATA_W-1:0]  din  [NUM_IN];
    logic [NUM_IN-1:0]  head_bad;
    logic [NUM_IN-1:0]  ready;
    logic [NUM_IN-1:0]  fire;
    logic [NUM_OUT-1:0] loadable;
    logic [NUM_OUT-1:0] sel_vld;
    logic [NUM_OUT-1:0] xfer;
    logic [SRC_W-1:0]   sel [NUM_OUT];
    logic [4:0]         ndrop;
    logic [SUM_W-1:0]   drop_sum;
    logic [CNT_W-1:0]   drop_cnt_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            dest[i]     = bus.in_dest[i*DEST_W +: DEST_W];
            din[i]      = bus.in_data[i*DATA_W +: DATA_W];
            head_bad[i] = (in_st_q[i] == InHead) && (32'(dest[i]) >= NUM_OUT);
        end
    end

    always_comb begin
        int unsigned      idx;
        logic [SRC_W-1:0] cand;
        logic             found;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned o = 0; o < NUM_OUT; o++) begin
            loadable[o] = !out_valid_q[o] || bus.out_ready[o];
            sel[o]      = '0;
            found       = 1'b0;
            if (out_st_q[o] == OutLocked) begin
                sel[o] = owner_q[o];
                found  = 1'b1;
            end else begin
                // Rotating search starting at the pointer; first eligible head wins.
                for (int unsigned k = 0; k < NUM_IN; k++) begin
                    idx = 32'(ptr_q[o]) + k;
                    if (idx >= NUM_IN) idx = idx - NUM_IN;
                    cand = SRC_W'(idx);
                    if (!found && bus.in_valid[cand] && (in_st_q[cand] == InHead) &&
                        (32'(dest[cand]) == o)) begin
                        sel[o] = cand;
                        found  = 1'b1;
                    end
                end
            end
            sel_vld[o] = found;
            xfer[o]    = found && loadable[o] && bus.in_valid[sel[o]];
        end

        ready = head_bad;
        ndrop = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (in_st_q[i] == InDrop) ready[i] = 1'b1;
            for (int unsigned o = 0; o < NUM_OUT; o++) begin
                if (sel_vld[o] && loadable[o] && (sel[o] == SRC_W'(i))) ready[i] = 1'b1;
            end
        end
        fire = bus.in_valid & ready;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            ndrop = ndrop + 5'(fire[i] && head_bad[i]);
        end

        drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(ndrop);
        drop_cnt_d = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_IN; i++) in_st_q[i] <= InHead;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (fire[i]) begin
                    case (in_st_q[i])
                        InHead: begin
                            if (!bus.in_last[i]) in_st_q[i] <= head_bad[i] ? InDrop : InFwd;
                        end
                        InFwd, InDrop: begin
                            if (bus.in_last[i]) in_st_q[i] <= InHead;
                        end
                        default: in_st_q[i] <= InHead;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NUM_OUT; o++) begin
                out_st_q[o] <= OutIdle;
                owner_q[o]  <= '0;
                ptr_q[o]    <= '0;
            end
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            for (int unsigned o = 0; o < NUM_OUT; o++) begin
                if (xfer[o]) begin
                    out_valid_q[o]                  <= 1'b1;
                    out_last_q[o]                   <= bus.in_last[sel[o]];
                    out_data_q[o*DATA_W +: DATA_W]  <= din[sel[o]];
                    out_src_q[o*SRC_W +: SRC_W]     <= sel[o];
                    if (out_st_q[o] == OutIdle) begin
                        ptr_q[o] <= (32'(sel[o]) == NUM_IN - 1) ? '0 : sel[o] + SRC_W'(1);
                        if (!bus.in_last[sel[o]]) begin
                            out_st_q[o] <= OutLocked;
                            owner_q[o]  <= sel[o];
                        end
                    end else if (bus.in_last[sel[o]]) begin
                        out_st_q[o] <= OutIdle;
                    end
                end else if (bus.out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule
